// File: rtl/instr_issuer.sv
// Instruction issuer: streams a small program memory to a processor one word at a time,
// handshaking each instruction with Run/Done and guarding each wait with a watchdog.
module instr_issuer #(
  parameter  int DEPTH   = 32,
  parameter  int TIMEOUT = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = $clog2(DEPTH + 1),
  localparam int WW      = $clog2(TIMEOUT + 1)
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Load_we,
  input  logic [AW-1:0] Load_addr,
  input  logic [15:0]   Load_data,
  input  logic [LW-1:0] Prog_len,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Finished,
  output logic          Timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISHED,
    S_ERROR
  } state_t;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [LW-1:0] start_len;
  logic [LW-1:0] cnt_inc;
  logic [15:0]   mem [DEPTH];

  assign start_len = (Prog_len > DEPTH_L) ? DEPTH_L : Prog_len;
  assign cnt_inc   = cnt_q + LW'(1);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE, S_FINISHED, S_ERROR: begin
        if (Start) begin
          len_d   = start_len;
          pc_d    = '0;
          cnt_d   = '0;
          wd_d    = '0;
          state_d = (start_len != '0) ? S_ISSUE : S_FINISHED;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done is checked before the watchdog so a last-cycle completion still counts
        if (Done) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_FINISHED;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = S_ISSUE;
          end
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Run      = (state_q == S_ISSUE);
    Busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
    Finished = (state_q == S_FINISHED);
    Timeout  = (state_q == S_ERROR);
    PC       = pc_q;
    DIN      = Busy ? mem[pc_q] : 16'h0000;
  end

  // Program memory is deliberately outside reset so a loaded program survives it
  always_ff @(posedge Clock) begin
    if (Load_we && !Busy) begin
      mem[Load_addr] <= Load_data;
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: a processor responder answers Run pulses, and a
// scoreboard of expected issue addresses plus a program-memory shadow checks every cycle.
module tb_instr_issuer;
  localparam int TO = 16;

  logic        Clock = 1'b0;
  logic        Resetn, Start, Load_we, Done;
  logic [4:0]  Load_addr;
  logic [15:0] Load_data;
  logic [5:0]  Prog_len;
  logic [15:0] DIN;
  logic        Run, Busy, Finished, Timeout;
  logic [4:0]  PC;

  instr_issuer #(.DEPTH(32), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Load_we(Load_we),
    .Load_addr(Load_addr), .Load_data(Load_data), .Prog_len(Prog_len), .Done(Done),
    .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Finished(Finished), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] mem_m [32];
  int          exp_q[$];
  logic [15:0] din_log[$];
  int          run_cnt = 0;
  logic [15:0] last_din = 16'h0;
  int          done_dly = 0;
  bit          done_force = 1'b0;
  int          timer = 0;
  int          exp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every Run must match the next expected address and its shadowed word
  always @(negedge Clock) begin
    if (Run) begin
      run_cnt++;
      last_din = DIN;
      din_log.push_back(DIN);
      if (exp_q.size() == 0) begin
        chk("unexpected_run", 32'd1, 32'd0);
      end else begin
        exp_addr = exp_q.pop_front();
        chk("run_pc", 32'(PC), 32'(exp_addr));
        chk("run_din", 32'(DIN), 32'(mem_m[exp_addr]));
      end
    end
    chk("status_exclusive", 32'(int'(Busy) + int'(Finished) + int'(Timeout) <= 1), 32'd1);
    if (!Busy) chk("din_idle_zero", 32'(DIN), 32'd0);
    else       chk("din_hold", 32'(DIN), 32'(mem_m[PC]));
  end

  // Processor model: Done done_dly cycles after each Run (0 = never answer)
  always begin
    @(posedge Clock); #1;
    Done = done_force;
    if (!Resetn) timer = 0;
    else if (Run && done_dly != 0) timer = done_dly;
    else if (timer > 0) begin
      timer--;
      if (timer == 0) Done = 1'b1;
    end
  end

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [15:0] d);
    Load_we = 1'b1; Load_addr = a; Load_data = d; mem_m[a] = d;
    step();
    Load_we = 1'b0;
  endtask

  task automatic start(input logic [5:0] len);
    Prog_len = len; Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic expect_seq(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i);
  endtask

  task automatic wait_end(input string name, input int max);
    int n = 0;
    while (!Finished && !Timeout && n < max) begin
      step();
      n++;
    end
    if (n >= max) chk({name, "_bound"}, 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_run"}, 32'(Run), 32'd0);
    chk({name, "_din"}, 32'(DIN), 32'd0);
    chk({name, "_pc"}, 32'(PC), 32'd0);
    chk({name, "_busy"}, 32'(Busy), 32'd0);
    chk({name, "_fin"}, 32'(Finished), 32'd0);
    chk({name, "_tmo"}, 32'(Timeout), 32'd0);
  endtask

  initial begin
    int n;
    Resetn = 1'b0; Start = 1'b0; Load_we = 1'b0; Load_addr = '0; Load_data = '0;
    Prog_len = '0; Done = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    Resetn = 1'b1;
    step();

    // Done in IDLE is ignored
    done_force = 1'b1; step(); step(); done_force = 1'b0; step();
    chk_all_zero("idle_done");

    // Three-instruction program; word 0 written in the same cycle as Start
    load(5'd1, 16'h3400);
    load(5'd2, 16'h5201);
    Load_we = 1'b1; Load_addr = 5'd0; Load_data = 16'h1205; mem_m[0] = 16'h1205;
    done_dly = 2; run_cnt = 0; din_log.delete(); expect_seq(3);
    Prog_len = 6'd3; Start = 1'b1;
    step();
    Load_we = 1'b0; Start = 1'b0;
    wait_end("t1", 60);
    chk("t1_fin", 32'(Finished), 32'd1);
    chk("t1_busy", 32'(Busy), 32'd0);
    chk("t1_runs", 32'(run_cnt), 32'd3);
    chk("t1_din0", 32'(din_log.size() > 0 ? din_log[0] : 16'h0), 32'h1205);
    chk("t1_din1", 32'(din_log.size() > 1 ? din_log[1] : 16'h0), 32'h3400);
    chk("t1_din2", 32'(din_log.size() > 2 ? din_log[2] : 16'h0), 32'h5201);
    chk("t1_pc_last", 32'(PC), 32'd2);

    // Zero-length program goes straight to FINISHED
    run_cnt = 0;
    start(6'd0);
    chk("t2_fin", 32'(Finished), 32'd1);
    chk("t2_busy", 32'(Busy), 32'd0);
    repeat (3) step();
    chk("t2_runs", 32'(run_cnt), 32'd0);

    // Done withheld: watchdog expiry exactly TO cycles after WAIT entry
    done_dly = 0; run_cnt = 0; expect_seq(1);
    start(6'd1);
    chk("t3_run", 32'(Run), 32'd1);
    step();
    n = 0;
    while (!Timeout && n < 100) begin
      step();
      n++;
    end
    chk("t3_latency", 32'(n), 32'(TO));
    chk("t3_tmo", 32'(Timeout), 32'd1);
    chk("t3_pc", 32'(PC), 32'd0);
    done_force = 1'b1; step(); step(); done_force = 1'b0; step();
    chk("t3_err_hold", 32'(Timeout), 32'd1);
    chk("t3_err_runs", 32'(run_cnt), 32'd1);
    done_dly = 2; expect_seq(1);
    start(6'd1);
    wait_end("t3r", 40);
    chk("t3r_fin", 32'(Finished), 32'd1);
    chk("t3r_din", 32'(last_din), 32'h1205);

    // Done on the final watchdog cycle wins over expiry
    done_dly = TO; run_cnt = 0; expect_seq(2);
    start(6'd2);
    wait_end("t4", 200);
    chk("t4_fin", 32'(Finished), 32'd1);
    chk("t4_tmo", 32'(Timeout), 32'd0);
    chk("t4_runs", 32'(run_cnt), 32'd2);

    // Write and Start during WAIT are both dropped
    done_dly = 0; run_cnt = 0; expect_seq(1);
    start(6'd1);
    step();
    Load_we = 1'b1; Load_addr = 5'd1; Load_data = 16'hDEAD;
    Prog_len = 6'd5; Start = 1'b1;
    step();
    Load_we = 1'b0; Start = 1'b0;
    chk("t5_busy", 32'(Busy), 32'd1);
    wait_end("t5", 100);
    chk("t5_tmo", 32'(Timeout), 32'd1);
    chk("t5_runs", 32'(run_cnt), 32'd1);
    done_dly = 2; run_cnt = 0; expect_seq(2);
    start(6'd2);
    wait_end("t5r", 60);
    chk("t5r_fin", 32'(Finished), 32'd1);
    chk("t5r_mem1", 32'(last_din), 32'h3400);

    // Full 32-word program, then an over-length Prog_len clamped to 32
    for (int i = 0; i < 32; i++) load(5'(i), 16'hA000 + 16'(i));
    done_dly = 1; run_cnt = 0; expect_seq(32);
    start(6'd32);
    wait_end("t6", 400);
    chk("t6_fin", 32'(Finished), 32'd1);
    chk("t6_runs", 32'(run_cnt), 32'd32);
    chk("t6_last", 32'(last_din), 32'hA01F);
    chk("t6_pc", 32'(PC), 32'd31);
    run_cnt = 0; expect_seq(32);
    start(6'd45);
    wait_end("t6c", 400);
    chk("t6c_fin", 32'(Finished), 32'd1);
    chk("t6c_runs", 32'(run_cnt), 32'd32);

    // Reset mid-WAIT aborts; no Run afterwards without a new Start
    done_dly = 0; run_cnt = 0; expect_seq(32);
    start(6'd32);
    step(); step();
    chk("t7_busy", 32'(Busy), 32'd1);
    Resetn = 1'b0;
    #1;
    chk_all_zero("t7_rst");
    exp_q.delete();
    step(); step();
    Resetn = 1'b1;
    repeat (20) step();
    chk("t7_runs", 32'(run_cnt), 32'd1);
    chk_all_zero("t7_idle");

    // Memory survives reset
    done_dly = 1; run_cnt = 0; expect_seq(1);
    start(6'd1);
    wait_end("t8", 40);
    chk("t8_fin", 32'(Finished), 32'd1);
    chk("t8_din", 32'(last_din), 32'hA000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 16-bit program memory words (address width 5).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the maximum WAIT cycles allowed for Done after a Run pulse.
REQ-003 Clock  input  1  clock; all state changes on the rising edge.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  begins program execution from address 0.
REQ-006 Load_we  input  1  program memory write enable.
REQ-007 Load_addr  input  5  program memory write address.
REQ-008 Load_data  input  16  program memory write data.
REQ-009 Prog_len  input  6  number of instructions to issue, 0..32; sampled when Start is accepted.
REQ-010 Done  input  1  processor instruction-complete strobe.
REQ-011 DIN  output  16  instruction word driven to the processor.
REQ-012 Run  output  1  processor start strobe, one cycle per instruction.
REQ-013 PC  output  5  address of the current instruction.
REQ-014 Busy  output  1  high in ISSUE and WAIT.
REQ-015 Finished  output  1  high in FINISHED.
REQ-016 Timeout  output  1  high in ERROR.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, FINISHED and ERROR.
REQ-018 IDLE/FINISHED/ERROR + Start=1: capture Prog_len into len_q, PC<=0, instruction counter cnt<=0; go to ISSUE if Prog_len!=0, else to FINISHED.
REQ-019 Start SHALL be ignored while Busy=1.
REQ-020 ISSUE: Run=1 and DIN=mem[PC] for exactly one cycle, then unconditionally go to WAIT; Done in ISSUE SHALL be ignored.
REQ-021 WAIT: Run=0 and DIN held at mem[PC] until exit; the watchdog counter SHALL increment each WAIT cycle, starting from 0 on entry.
REQ-022 WAIT + Done=1: cnt<=cnt+1; go to FINISHED if cnt+1==len_q, else PC<=PC+1 and go to ISSUE.
REQ-023 WAIT + Done=0 with watchdog==TIMEOUT-1: go to ERROR with PC frozen.
REQ-024 Done and watchdog expiry in the same cycle: Done SHALL win.
REQ-025 Done while in IDLE, FINISHED or ERROR SHALL be ignored.
REQ-026 PC SHALL be 5 bits; with len_q=32, the last instruction issued is at address 31 and FINISHED is entered without PC wrapping.
REQ-027 Prog_len values >32 SHALL be treated as 32.
REQ-028 Load_we=1 with Busy=0: mem[Load_addr]<=Load_data on the clock edge.
REQ-029 Load_we=1 with Busy=1: the write SHALL be dropped.
REQ-030 A write and a Start in the same cycle: the write SHALL complete first, so the new word is visible to the first ISSUE.
REQ-031 DIN SHALL be 0 in IDLE, FINISHED and ERROR.
REQ-032 Outputs SHALL be registered or decoded from registered state only, with no combinational path from Done to Run or DIN.

Reset
REQ-033 Resetn=0 SHALL immediately force state IDLE, PC=0, cnt=0, watchdog=0, len_q=0, Run=0, DIN=0, Busy=0, Finished=0, Timeout=0.
REQ-034 Program memory contents SHALL NOT be affected by reset.
REQ-035 Reset during ISSUE or WAIT SHALL abort the program with no further Run pulse after release.
REQ-036 After reset release, the first action SHALL require a new Start.

Verification
REQ-037 Load mem[0..2]={16'h1205,16'h3400,16'h5201}, Prog_len=3, Start; model answers Done 2 cycles after each Run -> three Run pulses with DIN 1205, 3400, 5201 in order; PC 0,1,2; Finished=1; Busy=0.
REQ-038 Prog_len=0, Start -> FINISHED the next cycle, no Run pulse.
REQ-039 Prog_len=1, Done withheld -> Timeout=1 exactly TIMEOUT cycles after WAIT entry, PC=0; Start then reissues mem[0].
REQ-040 Done asserted on the final watchdog cycle -> Timeout=0 and the program continues.
REQ-041 Load_we during WAIT targeting addr 1 -> mem[1] unchanged, verified by reissue; Start while Busy -> ignored.
REQ-042 Prog_len=32, Done after 1 cycle -> 32 Run pulses, last DIN=mem[31], Finished=1; Resetn pulsed mid-WAIT on a rerun -> IDLE, Run stays 0.
